// File: rtl/hash_table_bank.sv
// Storage bank behind the hash-table controller: per-table key/data RAMs with
// valid flags, a post-reset/clear invalidation sweep and a live occupancy count.
module hash_table_bank #(
  parameter int KEY_WIDTH           = 4,
  parameter int DATA_WIDTH          = 8,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int HASH_TABLE_MAX_SIZE = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  clear_i,
  input  logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0]  hash_adr_i,
  input  logic [NUMBER_OF_TABLES-1:0]                           write_en_i,
  input  logic [NUMBER_OF_TABLES-1:0]                           write_valid_flag_i,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH+DATA_WIDTH-1:0] keys_data_i,
  output logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH+DATA_WIDTH-1:0] read_out_keys_data_o,
  output logic [NUMBER_OF_TABLES-1:0]                           valid_flags_o,
  output logic                                                  ready_o,
  output logic [$clog2(NUMBER_OF_TABLES*2**HASH_TABLE_MAX_SIZE+1)-1:0] occupancy_o
);

  localparam int DEPTH = 2 ** HASH_TABLE_MAX_SIZE;
  localparam int KD_W  = KEY_WIDTH + DATA_WIDTH;
  localparam int OCC_W = $clog2(NUMBER_OF_TABLES * DEPTH + 1);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                     state_reg;
  logic [HASH_TABLE_MAX_SIZE-1:0] cnt_reg;
  logic [OCC_W-1:0]               occ_reg;
  logic [OCC_W-1:0]               occ_next;
  logic                           run;
  logic [NUMBER_OF_TABLES-1:0]    wr_en;
  logic [NUMBER_OF_TABLES-1:0]    old_valid;

  assign run   = (state_reg == RUN);
  // A clear or reset in the same cycle drops every write.
  assign wr_en = {NUMBER_OF_TABLES{run & ~clear_i & ~rst}} & write_en_i;

  always_comb begin
    occ_next = occ_reg;
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      if (wr_en[t]) begin
        if (!old_valid[t] && write_valid_flag_i[t])
          occ_next = occ_next + OCC_W'(1);
        else if (old_valid[t] && !write_valid_flag_i[t])
          occ_next = occ_next - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
      occ_reg   <= '0;
    end else begin
      case (state_reg)
        INIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (&cnt_reg)
            state_reg <= RUN;
        end
        default: begin
          if (clear_i) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
            occ_reg   <= '0;
          end else begin
            occ_reg <= occ_next;
          end
        end
      endcase
    end
  end

  assign ready_o     = run;
  assign occupancy_o = occ_reg;

  generate
    for (genvar gi = 0; gi < NUMBER_OF_TABLES; gi++) begin : g_table
      logic [KD_W-1:0]  mem [DEPTH];
      logic [DEPTH-1:0] valid_reg;
      logic [KD_W-1:0]  rd_reg;
      logic             vf_reg;

      assign old_valid[gi] = valid_reg[hash_adr_i[gi]];

      always_ff @(posedge clk) begin
        if (wr_en[gi])
          mem[hash_adr_i[gi]] <= keys_data_i[gi];
      end

      // Read-first: the registered output captures the pre-write contents.
      always_ff @(posedge clk) begin
        if (rst || !run) begin
          rd_reg <= '0;
          vf_reg <= 1'b0;
        end else begin
          rd_reg <= mem[hash_adr_i[gi]];
          vf_reg <= valid_reg[hash_adr_i[gi]];
        end
      end

      always_ff @(posedge clk) begin
        if (!run)
          valid_reg[cnt_reg] <= 1'b0;
        else if (wr_en[gi])
          valid_reg[hash_adr_i[gi]] <= write_valid_flag_i[gi];
      end

      assign read_out_keys_data_o[gi] = rd_reg;
      assign valid_flags_o[gi]        = vf_reg;
    end
  endgenerate

endmodule

// File: tb/tb_hash_table_bank.sv
// Directed bench for hash_table_bank: read results are scoreboarded when the
// read address is driven and compared one cycle later.
module tb_hash_table_bank;

  localparam int N = 3;
  localparam int H = 4;
  localparam int KD = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear_i;
  logic [N-1:0][H-1:0]  hash_adr_i;
  logic [N-1:0]         write_en_i;
  logic [N-1:0]         write_valid_flag_i;
  logic [N-1:0][KD-1:0] keys_data_i;
  logic [N-1:0][KD-1:0] read_out_keys_data_o;
  logic [N-1:0]         valid_flags_o;
  logic                 ready_o;
  logic [5:0]           occupancy_o;

  hash_table_bank #(
    .KEY_WIDTH(4), .DATA_WIDTH(8), .NUMBER_OF_TABLES(N), .HASH_TABLE_MAX_SIZE(H)
  ) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .hash_adr_i(hash_adr_i),
    .write_en_i(write_en_i), .write_valid_flag_i(write_valid_flag_i),
    .keys_data_i(keys_data_i), .read_out_keys_data_o(read_out_keys_data_o),
    .valid_flags_o(valid_flags_o), .ready_o(ready_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [KD-1:0] kd;
    logic        vf;
    bit          ck_kd;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int t, input logic [H-1:0] adr, input logic [KD-1:0] kd,
                    input logic vf, input bit ck_kd, input string tag);
    exp_t e;
    hash_adr_i[t] = adr;
    e.t = t; e.kd = kd; e.vf = vf; e.ck_kd = ck_kd; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wr(input int t, input logic [H-1:0] adr, input logic [KD-1:0] kd,
                    input logic flag);
    hash_adr_i[t]         = adr;
    write_en_i[t]         = 1'b1;
    write_valid_flag_i[t] = flag;
    keys_data_i[t]        = kd;
  endtask

  // Advance one clock, release write strobes, then drain the scoreboard.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    write_en_i = '0;
    clear_i    = 1'b0;
    $display("txn t=%0t ready=%0b occ=%0d vf=%b rd0=%h rd1=%h rd2=%h", $time, ready_o,
             occupancy_o, valid_flags_o, read_out_keys_data_o[0],
             read_out_keys_data_o[1], read_out_keys_data_o[2]);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_vf"}, 32'(valid_flags_o[e.t]), 32'(e.vf));
      if (e.ck_kd)
        chk({e.tag, "_kd"}, 32'(read_out_keys_data_o[e.t]), 32'(e.kd));
    end
  endtask

  task automatic sweep_wait(input string tag);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk($sformatf("%s_ready%0d", tag, i), 32'(ready_o), 32'(i == 16));
      chk($sformatf("%s_occ%0d", tag, i), 32'(occupancy_o), 32'd0);
      if (i < 16)
        chk($sformatf("%s_vf%0d", tag, i), 32'(valid_flags_o), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; clear_i = 1'b0; hash_adr_i = '0; write_en_i = '0;
    write_valid_flag_i = '0; keys_data_i = '0;

    // 1. reset state and initial sweep
    cyc(); cyc();
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_occ", 32'(occupancy_o), 32'd0);
    chk("rst_vf", 32'(valid_flags_o), 32'd0);
    chk("rst_rd", 32'(read_out_keys_data_o), 32'd0);
    rst = 1'b0;
    sweep_wait("init");

    // 2. single write then read back
    wr(1, 4'hB, 12'hABB, 1'b1);
    cyc();
    rd(1, 4'hB, 12'hABB, 1'b1, 1'b1, "t1_B");
    cyc();
    chk("occ_after_t1", 32'(occupancy_o), 32'd1);

    // 3. dual write, valid overwrite, invalidate
    wr(0, 4'hF, 12'hFFF, 1'b1);
    wr(2, 4'h3, 12'h444, 1'b1);
    cyc();
    chk("occ_dual", 32'(occupancy_o), 32'd3);
    wr(0, 4'hF, 12'hFFF, 1'b1);
    cyc();
    chk("occ_rewrite", 32'(occupancy_o), 32'd3);
    wr(0, 4'hF, 12'hFFF, 1'b0);
    cyc();
    chk("occ_invalidate", 32'(occupancy_o), 32'd2);
    rd(0, 4'hF, 12'hFFF, 1'b0, 1'b1, "t0_F");
    rd(2, 4'h3, 12'h444, 1'b1, 1'b1, "t2_3");
    cyc();

    // 4. read-during-write returns old contents
    wr(1, 4'h7, 12'h888, 1'b1);
    cyc();
    chk("occ_t1_7", 32'(occupancy_o), 32'd3);
    wr(1, 4'h7, 12'h777, 1'b1);
    rd(1, 4'h7, 12'h888, 1'b1, 1'b1, "rdw_old");
    cyc();
    rd(1, 4'h7, 12'h777, 1'b1, 1'b1, "rdw_new");
    cyc();
    chk("occ_rdw", 32'(occupancy_o), 32'd3);

    // 5. clear with a concurrent write that must be dropped
    clear_i = 1'b1;
    wr(2, 4'h5, 12'h555, 1'b1);
    cyc();
    chk("clr_ready", 32'(ready_o), 32'd0);
    chk("clr_occ", 32'(occupancy_o), 32'd0);
    sweep_wait("clr");
    rd(0, 4'hF, 12'h0, 1'b0, 1'b0, "clr_t0_F");
    rd(1, 4'hB, 12'h0, 1'b0, 1'b0, "clr_t1_B");
    rd(2, 4'h3, 12'h0, 1'b0, 1'b0, "clr_t2_3");
    cyc();
    rd(1, 4'h7, 12'h0, 1'b0, 1'b0, "clr_t1_7");
    rd(2, 4'h5, 12'h0, 1'b0, 1'b0, "clr_t2_5");
    cyc();
    chk("clr_occ_run", 32'(occupancy_o), 32'd0);

    // 6. reset in the middle of a sweep
    clear_i = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) cyc();
    chk("mid_ready", 32'(ready_o), 32'd0);
    rst = 1'b1;
    cyc();
    chk("mid_rst_ready", 32'(ready_o), 32'd0);
    rst = 1'b0;
    sweep_wait("mid");

    // function after restart
    wr(0, 4'h2, 12'h5A5, 1'b1);
    cyc();
    chk("post_occ", 32'(occupancy_o), 32'd1);
    rd(0, 4'h2, 12'h5A5, 1'b1, 1'b1, "post_t0_2");
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hash_table_bank.md
Name: hash_table_bank

Overview:
- Storage side of the hash-table controller interface. Holds NUMBER_OF_TABLES independent tables of 2**HASH_TABLE_MAX_SIZE entries. Each entry stores key+data and one valid flag.
- Each cycle it executes the controller's per-table write enables, key/data and valid-flag writes. It returns the registered read-out key/data and valid flags at the addressed entries.
- Adds a post-reset/clear sweep that invalidates every entry, and a live occupancy counter.

Parameters:
- KEY_WIDTH, 4, key bits per entry
- DATA_WIDTH, 8, data bits per entry
- NUMBER_OF_TABLES, 3, number of independent tables
- HASH_TABLE_MAX_SIZE, 4, address bits per table (depth 2**HASH_TABLE_MAX_SIZE)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear_i  in  1  request full invalidation sweep (honoured only in RUN)
- hash_adr_i  in  [HASH_TABLE_MAX_SIZE-1:0] x NUMBER_OF_TABLES  per-table read/write address
- write_en_i  in  1 x NUMBER_OF_TABLES  per-table write strobe
- write_valid_flag_i  in  1 x NUMBER_OF_TABLES  valid flag written with the entry
- keys_data_i  in  [KEY_WIDTH+DATA_WIDTH-1:0] x NUMBER_OF_TABLES  {key,data} written
- read_out_keys_data_o  out  [KEY_WIDTH+DATA_WIDTH-1:0] x NUMBER_OF_TABLES  registered entry contents
- valid_flags_o  out  1 x NUMBER_OF_TABLES  registered valid flags
- ready_o  out  1  high in RUN; low during the sweep
- occupancy_o  out  $clog2(NUMBER_OF_TABLES*2**HASH_TABLE_MAX_SIZE+1)  number of valid entries, all tables

Behaviour:
- Reset (rst=1 at a clk edge):
  - state<=INIT, sweep counter<=0.
  - ready_o=0, occupancy_o=0, read_out_keys_data_o=0, valid_flags_o=0.
  - Key/data storage is not reset; valid bits are cleared by the sweep.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle clear the valid bit at address = sweep counter in all tables, then increment the counter.
  - After address 2**HASH_TABLE_MAX_SIZE-1 is cleared, go to RUN. INIT lasts exactly 2**HASH_TABLE_MAX_SIZE cycles, and ready_o rises on the following cycle.
  - write_en_i and clear_i are ignored.
  - valid_flags_o forced 0, read_out_keys_data_o forced 0, occupancy_o held 0.
- RUN, clear_i=1:
  - Go to INIT with counter=0 and occupancy_o<=0 on the same edge.
  - Writes presented in that cycle are dropped.
- RUN, reads:
  - Every table is read at hash_adr_i[t] every cycle.
  - read_out_keys_data_o[t] and valid_flags_o[t] are registered and appear 1 cycle later.
- RUN, writes:
  - If write_en_i[t]=1: entry[t][hash_adr_i[t]] <= keys_data_i[t] and valid[t][hash_adr_i[t]] <= write_valid_flag_i[t].
  - Write takes effect at the edge.
- Read-during-write, same table and address: read-first. The output shows the old contents and old flag; the new value is visible on the next read.
- Tables are fully independent; any subset may write in the same cycle.
- Occupancy, per written table:
  - +1 if old valid=0 and new valid=1.
  - −1 if old valid=1 and new valid=0.
  - 0 otherwise, including overwriting a valid entry with valid=1.
  - Deltas from all tables are summed in one cycle.
- Occupancy range: 0 to NUMBER_OF_TABLES*2**HASH_TABLE_MAX_SIZE. It never wraps, because the rules above make overflow and underflow impossible.
- rst mid-INIT or mid-RUN: immediate restart of INIT from address 0; all in-flight writes are dropped.

Test Plan (defaults; depth 16):
1. Reset, then release → ready_o=0 for 16 cycles after release, then 1; valid_flags_o={0,0,0}; occupancy_o=0.
2. In RUN, write table1 adr 4'hB, keys_data 12'hABB, flag 1; next cycle read adr 4'hB → read_out_keys_data_o[1]=12'hABB, valid_flags_o[1]=1, occupancy_o=1.
3. Same cycle: write table0 adr 4'hF=12'hFFF, table2 adr 4'h3=12'h444, both flag 1 → occupancy_o +2. Then rewrite table0 adr 4'hF with flag 1 → occupancy_o unchanged. Then write it with flag 0 → occupancy_o −1.
4. Read-during-write: table1 adr 4'h7 holds 12'h888 valid; write 12'h777 at adr 4'h7 while reading it → output 12'h888 that cycle, 12'h777 the next.
5. With occupancy 3, pulse clear_i together with write_en_i on table2 → ready_o=0 for 16 cycles, occupancy_o=0, and all prior addresses read valid=0 after RUN resumes; the table2 write is absent.
6. Assert rst at sweep address 8 → the sweep restarts; ready_o stays low for a full 16 cycles after rst falls.
